// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if: block-in, round-key fetch and block-out bundle (blk_cnt only with AES_BLK_CNT_EN)
interface aes_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_BLK_CNT_EN
    logic [31:0]  blk_cnt;
    modport master(output in_valid, in_data, rk_data, out_ready,
                   input in_ready, rk_idx, out_valid, out_data, busy, blk_cnt);
    modport slave(input in_valid, in_data, rk_data, out_ready,
                  output in_ready, rk_idx, out_valid, out_data, busy, blk_cnt);
`else
    modport master(output in_valid, in_data, rk_data, out_ready,
                   input in_ready, rk_idx, out_valid, out_data, busy);
    modport slave(input in_valid, in_data, rk_data, out_ready,
                  output in_ready, rk_idx, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption, one round per clock on a registered state; AES_BLK_CNT_EN adds blk_cnt
module aes_round_engine #(
    parameter int NR = 10
) (
    input logic clk,
    input logic rst,
    aes_round_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_round_engine: NR must be 10, 12 or 14");
    end

    state_t       st;
    logic [3:0]   r;
    logic [127:0] state_reg;
    logic [127:0] out_q;
    logic [127:0] sub_shift;
    logic [127:0] mixed;
    logic         load;
    logic         retire;
`ifdef AES_BLK_CNT_EN
    logic [31:0]  blk_q;
    assign bus.blk_cnt = blk_q;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // inverse computed as x^254 (maps 0 to 0), followed by the affine transform
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] y;
        p = x;
        y = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            y = gf_mul(y, p);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] t;
        for (int k = 0; k < 16; k++)
            t[127-8*k -: 8] = sub_byte(s[127-8*k -: 8]);
        return t;
    endfunction

    // byte 4c+j is row j, column c; row j rotates left by j columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
                t[127-8*(4*c+j) -: 8] = s[127-8*(4*((c+j)%4)+j) -: 8];
        return t;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            t[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return t;
    endfunction

    assign load          = bus.in_valid && bus.in_ready;
    assign retire        = (st == DONE) && bus.out_ready;
    assign bus.in_ready  = !rst && (st == IDLE || retire);
    assign bus.rk_idx    = (st == ROUND) ? r : 4'd0;
    assign bus.out_valid = (st == DONE);
    assign bus.busy      = (st != IDLE);
    assign bus.out_data  = out_q;

    // shared round datapath: the final round taps sub_shift, full rounds tap mixed
    always_comb begin
        sub_shift = shift_rows(sub_bytes(state_reg));
        mixed     = mix_columns(sub_shift);
    end

    // control FSM, state register, ciphertext register and block counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            r         <= 4'd0;
            state_reg <= 128'd0;
            out_q     <= 128'd0;
`ifdef AES_BLK_CNT_EN
            blk_q     <= 32'd0;
`endif
        end else begin
            if (load) begin
                state_reg <= bus.in_data ^ bus.rk_data;
                r         <= 4'd1;
                st        <= ROUND;
            end else if (st == ROUND && r == LAST) begin
                out_q <= sub_shift ^ bus.rk_data;
                st    <= DONE;
            end else if (st == ROUND) begin
                state_reg <= mixed ^ bus.rk_data;
                r         <= r + 4'd1;
            end else if (retire) begin
                st <= IDLE;
            end
`ifdef AES_BLK_CNT_EN
            if (retire)
                blk_q <= blk_q + 32'd1;
`endif
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: checks NR=10/12/14 engines against known answers and a byte-level AES model
module tb_aes_round_engine;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   iv, ordy, ir, ov, bsy;
    logic [127:0] idata [3];
    logic [127:0] od [3];
    logic [3:0]   rk [3];
    logic [127:0] rk_rom [3][15];
`ifdef AES_BLK_CNT_EN
    logic [31:0]  cnt [3];
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_engine_if bus();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idata[g];
        assign bus.out_ready = ordy[g];
        assign bus.rk_data   = rk_rom[g][bus.rk_idx];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign bsy[g]        = bus.busy;
        assign od[g]         = bus.out_data;
        assign rk[g]         = bus.rk_idx;
`ifdef AES_BLK_CNT_EN
        assign cnt[g]        = bus.blk_cnt;
`endif
        aes_round_engine #(.NR(10 + 2 * g)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    end

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8 * int'(x) -: 8];
    endfunction

    // polynomial product then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // key schedule into the ROM of engine d (key is left-aligned)
    task automatic load_key(input int d, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr, nk;
        nr = 10 + 2 * d;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) rk_rom[d][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] aes_ref(input int d, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        int nr;
        nr = 10 + 2 * d;
        x = pt ^ rk_rom[d][0];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int k = 0; k < 16; k++) t[k] = sb(x[127-8*k -: 8]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    t[4*c+j] = (rnd == nr) ? s[4*c+j] :
                        gm(8'h02, s[4*c+j]) ^ gm(8'h03, s[4*c+(j+1)%4]) ^ s[4*c+(j+2)%4] ^ s[4*c+(j+3)%4];
            for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
            x = x ^ rk_rom[d][rnd];
        end
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // one block: accept, rk_idx walk, latency, ciphertext, retirement
    task automatic run(input int d, input logic [127:0] pt, input logic [127:0] exp, input string nm);
        logic ok;
        int nr;
        nr = 10 + 2 * d;
        @(negedge clk);
        chk({nm, " in_ready"}, ir[d], 1'b1);
        chk({nm, " rk_idx accept"}, rk[d], 4'd0);
        iv[d] = 1'b1;
        idata[d] = pt;
        ordy[d] = 1'b0;
        @(negedge clk);
        iv[d] = 1'b0;
        ok = 1'b1;
        for (int j = 1; j <= nr; j++) begin
            if (rk[d] != 4'(j) || ov[d] || !bsy[d]) ok = 1'b0;
            idata[d] = rnd128();
            @(negedge clk);
        end
        chk({nm, " rk_idx walk"}, ok, 1'b1);
        chk({nm, " out_valid latency"}, ov[d], 1'b1);
        chk({nm, " out_data"}, od[d], exp);
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk({nm, " retired"}, ov[d], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [$];
        logic [127:0] pts [4];
        logic [127:0] exps [4];
        logic [127:0] ctr;
        logic [31:0]  ecnt;
        logic         ok;
        logic         adv;
        int           nin, nout, last, cyc, d;
        iv = '0;
        ordy = '0;
        for (int i = 0; i < 3; i++) idata[i] = '0;
        vecs.push_back('{0, K128, PT, CT0});
        vecs.push_back('{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, PT,
                         128'hdda97ca4864cdfe06eaf70a0ec0d7191});
        vecs.push_back('{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, PT,
                         128'h8ea2b7ca516745bfeafc49904b496089});
        vecs.push_back('{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                         128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32});
        for (int i = 0; i < 3; i++) load_key(i, vecs[i].key);

        // reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("in_ready during reset", ir[i], 1'b0);
            chk("busy during reset", bsy[i], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset out_valid", ov[i], 1'b0);
            chk("reset rk_idx", rk[i], 4'd0);
            chk("reset out_data", od[i], 128'd0);
            chk("idle in_ready", ir[i], 1'b1);
`ifdef AES_BLK_CNT_EN
            chk("reset blk_cnt", cnt[i], 32'd0);
`endif
        end

        // known-answer table
        for (int i = 0; i < vecs.size(); i++) begin
            load_key(vecs[i].d, vecs[i].key);
            run(vecs[i].d, vecs[i].pt, vecs[i].ct, $sformatf("kat%0d", i));
        end

        // random keys and blocks against the model
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 2);
            load_key(d, {rnd128(), rnd128()});
            ctr = rnd128();
            run(d, ctr, aes_ref(d, ctr), $sformatf("rand%0d nr%0d", i, 10 + 2 * d));
        end

        // backpressure: output held, in_valid pulses ignored, single retirement
        load_key(0, K128);
        @(negedge clk);
        iv[0] = 1'b1;
        idata[0] = PT;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp out_valid", ov[0], 1'b1);
`ifdef AES_BLK_CNT_EN
        ecnt = cnt[0] + 32'd1;
`endif
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            iv[0] = !k[0];
            idata[0] = rnd128();
            @(negedge clk);
            if (od[0] !== CT0 || ir[0] || !ov[0]) ok = 1'b0;
        end
        chk("bp held stable, in_ready low", ok, 1'b1);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("bp retire out_valid", ov[0], 1'b0);
        chk("bp retire busy", bsy[0], 1'b0);
`ifdef AES_BLK_CNT_EN
        chk("bp blk_cnt +1", cnt[0], ecnt);
`endif
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ov[0] || bsy[0]) ok = 1'b0;
        end
        chk("bp single retirement", ok, 1'b1);

        // back-to-back: in_valid and out_ready held high
        for (int k = 0; k < 4; k++) begin
            pts[k] = rnd128();
            exps[k] = aes_ref(0, pts[k]);
        end
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        idata[0] = pts[0];
        nin = 0;
        nout = 0;
        last = 0;
        adv = 1'b0;
        for (cyc = 0; cyc < 200 && nout < 4; cyc++) begin
            if (ov[0]) begin
                chk($sformatf("b2b out_data %0d", nout), od[0], exps[nout]);
                if (nout > 0) chk("b2b spacing", cyc - last, 11);
                last = cyc;
                nout++;
            end
            if (iv[0] && ir[0]) begin
                chk("b2b rk_idx on reload", rk[0], 4'd0);
                nin++;
                adv = 1'b1;
            end
            @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                if (nin < 4) idata[0] = pts[nin];
                else iv[0] = 1'b0;
            end
        end
        chk("b2b blocks emitted", nout, 4);
        ordy[0] = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);

        // async reset at round 5 discards the block
        iv[0] = 1'b1;
        idata[0] = PT;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst precondition round 5", rk[0], 4'd5);
        #2 rst = 1'b1;
        #1;
        chk("rst busy async", bsy[0], 1'b0);
        chk("rst rk_idx async", rk[0], 4'd0);
        chk("rst in_ready forced low", ir[0], 1'b0);
`ifdef AES_BLK_CNT_EN
        chk("rst blk_cnt cleared", cnt[0], 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        // async reset while the result waits in DONE
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst done precondition", ov[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst out_valid async", ov[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (13) begin
            @(negedge clk);
            if (ov[0]) ok = 1'b0;
        end
        chk("rst nothing emitted", ok, 1'b1);
        run(0, PT, CT0, "post-reset kat");

`ifdef AES_BLK_CNT_EN
        // counter wrap
        @(negedge clk);
        force g_dut[0].u_dut.blk_q = 32'hFFFFFFFE;
        @(negedge clk);
        release g_dut[0].u_dut.blk_q;
        ecnt = 32'hFFFFFFFE;
        for (int k = 0; k < 3; k++) begin
            ecnt = ecnt + 32'd1;
            ctr = rnd128();
            run(0, ctr, aes_ref(0, ctr), $sformatf("cnt%0d", k));
            chk($sformatf("blk_cnt wrap %0d", k), cnt[0], ecnt);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES encryption datapath that replaces the single-shot combinational last round with a multi-cycle engine executing the initial AddRoundKey, NR-1 full rounds and the final round (no MixColumns) on one registered 128-bit state. Parametrised for AES-128/192/256 by round count. Sits between the block-input buffer and the ciphertext output stage. Round keys come from an external, pre-expanded key store addressed by the engine.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14; any other value is an elaboration error
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- in_valid  input  1  plaintext block offered
- in_ready  output  1  engine can accept a block this cycle
- in_data  input  128  plaintext; byte 0 at [127:120], FIPS-197 column-major order (byte 4c+r = state[r][c])
- rk_idx  output  4  index of round key required this cycle (0..NR)
- rk_data  input  128  round key rk_idx, same byte order; supplied combinationally, sampled at the clock edge
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts ciphertext
- out_data  output  128  ciphertext, registered
- busy  output  1  high in ROUND and DONE states
- blk_cnt  output  32  completed-block counter (only with AES_BLK_CNT_EN)

## Operation
- States: IDLE, ROUND, DONE; round counter r, 4 bits.
- IDLE: in_ready=1, rk_idx=0. On in_valid&&in_ready: state_reg <= in_data ^ rk_data, r <= 1, go ROUND.
- ROUND: rk_idx=r, in_ready=0, in_valid ignored.
  - r<NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_data; r <= r+1.
  - r==NR: out_data <= ShiftRows(SubBytes(state_reg)) ^ rk_data; go DONE.
- DONE: out_valid=1; out_data held stable until out_valid&&out_ready.
  - out_ready=0: remain DONE.
  - out_ready=1, in_valid=0: go IDLE.
  - out_ready=1, in_valid=1: in_ready=1 and rk_idx=0 this cycle; output retires and new block loads (state_reg <= in_data ^ rk_data, r <= 1, go ROUND) at the same edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready), forced 0 while rst is high.
- SubBytes, ShiftRows and MixColumns use the team's existing sub_byte, shift_rows and column-mix blocks. All byte reordering is internal; both ports are in FIPS-197 order.
- The engine never reads rk_data outside the cycle in which rk_idx points at it.

## Timing
- Reset (async assert, sync release): state IDLE, r=0, state_reg=0, out_data=0, out_valid=0, busy=0, rk_idx=0, blk_cnt=0.
- Latency: block accepted at edge E0 -> out_valid high after edge E0+NR.
- Throughput with out_ready held high and in_valid held high: one block per NR+1 cycles.
- rk_idx sequence for one block: 0 (accept cycle), 1, 2, ... NR.
- Reset mid-operation: block discarded, out_valid drops asynchronously, nothing emitted, blk_cnt cleared.
- in_data changes while in_ready=0 have no effect.

## Configuration
- AES_BLK_CNT_EN defined: 32-bit blk_cnt port present. It increments on every out_valid&&out_ready, wraps from 0xFFFFFFFF to 0, and resets to 0.
- AES_BLK_CNT_EN undefined: blk_cnt port and its register are absent. Datapath behaviour is identical.

## Test plan
- NR=10, key 000102030405060708090a0b0c0d0e0f (bench key-schedule ROM), plaintext 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
- NR=12, key 000102...1617, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191. NR=14, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: out_ready low 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> single retirement.
- Back-to-back: 4 blocks with in_valid and out_ready held high -> 4 correct ciphertexts spaced NR+1 cycles apart. rk_idx returns to 0 on each reload cycle.
- Reset asserted at round 5 -> out_valid=0 immediately, state IDLE. Next block encrypts correctly.
- AES_BLK_CNT_EN: preload the counter to 0xFFFFFFFE via a bench force, complete 3 blocks -> blk_cnt sequence FFFFFFFF, 0, 1.
